imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_pkg.sv | 28 ++
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory subsystem: loader state encoding,
// default memory depth and the opcode constants used by the instruction memory.
package imem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_LO = 3'd1,
        GET_HI = 3'd2,
        WRITE  = 3'd3,
        FINISH = 3'd4
    } loader_state_e;

    localparam int DEPTH_BYTES_DEFAULT = 32;

    // Major opcode field, bits [15:12] of each 16-bit instruction word.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/imem_loader.sv
// Streams a byte-serial program image into the instruction memory as 16-bit halfword writes.
// Optional running checksum of written words is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = DEPTH_BYTES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       len_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [15:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       checksum
);

    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(DEPTH_BYTES - 1);

    loader_state_e     state_q;
    loader_state_e     state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       cnt_q;
    logic [7:0]        lo_q;
    logic [7:0]        hi_q;
    logic [ADDR_W-1:0] addr_hi;
    logic              in_range;
    logic              xfer;

    assign xfer     = in_valid && in_ready;
    assign addr_hi  = addr_q + ADDR_W'(1);
    // The high byte lands at addr_q+1; the whole halfword must fit inside the memory.
    assign in_range = (addr_hi <= LAST_BYTE);

    assign busy  = (state_q != IDLE);
    assign waddr = addr_q;
    assign wdata = {hi_q, lo_q};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d  = state_q;
        in_ready = 1'b0;
        we       = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len_words == 16'd0) ? FINISH : GET_LO;
                end
            end
            GET_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_d = GET_HI;
            end
            GET_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_d = WRITE;
            end
            WRITE: begin
                if (in_range) begin
                    we      = 1'b1;
                    state_d = (cnt_q == 16'd1) ? FINISH : GET_LO;
                end else begin
                    error   = 1'b1;
                    state_d = IDLE;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q <= base_addr;
                        cnt_q  <= len_words;
                    end
                end
                GET_LO: if (xfer) lo_q <= in_data;
                GET_HI: if (xfer) hi_q <= in_data;
                WRITE: begin
                    if (in_range) begin
                        addr_q <= addr_q + ADDR_W'(2);
                        cnt_q  <= cnt_q - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state_q == IDLE && start) begin
            sum_q <= '0;
        end else if (we) begin
            sum_q <= sum_q + wdata;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes/done/error events,
// a negedge monitor pops and compares them whenever the DUT strobes an output.
module tb_imem_loader;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       len_words;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [15:0]       wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       checksum;

    typedef enum int {EV_WRITE = 0, EV_DONE = 1, EV_ERROR = 2} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] tx[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH_BYTES(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len_words (len_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_sum(input logic [15:0] v);
`ifdef IMEM_LOADER_CHECKSUM_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    function automatic ev_t mk(input ev_kind_e k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic observe(input ev_kind_e kind);
        ev_t e;
        check("event_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            if (kind == EV_WRITE) begin
                check("waddr", 32'(waddr), 32'(e.addr));
                check("wdata", 32'(wdata), 32'(e.data));
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (we)    observe(EV_WRITE);
            if (done)  observe(EV_DONE);
            if (error) observe(EV_ERROR);
        end
    end

    task automatic start_load(input logic [15:0] base, input logic [15:0] len);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        len_words = len;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // pattern 0: in_valid always high; pattern 1: in_valid follows 1,0,0,1 repeating.
    task automatic send_bytes(input string name, input int pattern, input bit inject);
        int idx = 0;
        int cyc = 0;
        while (idx < tx.size() && cyc < 200) begin
            @(posedge clk); #1;
            in_valid = (pattern == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            in_data  = tx[idx];
            start    = inject && (cyc == 2);
            if (start) begin
                base_addr = 16'h0010;
                len_words = 16'd5;
            end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
        check({name, "_bytes_taken"}, 32'(idx), 32'(tx.size()));
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        do begin
            @(posedge clk); #2;
            cyc++;
        end while ((exp_q.size() != 0 || busy) && cyc < 50);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len_words = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we",       32'(we), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_error",    32'(error), 32'd0);
        check("rst_waddr",    32'(waddr), 32'd0);
        check("rst_wdata",    32'(wdata), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);

        // Basic two-word load.
        tx = '{8'h1F, 8'h30, 8'hFE, 8'h0F};
        exp_q.push_back(mk(EV_WRITE, 16'h0000, 16'h301F));
        exp_q.push_back(mk(EV_WRITE, 16'h0002, 16'h0FFE));
        exp_q.push_back(mk(EV_DONE, 16'h0, 16'h0));
        start_load(16'h0000, 16'd2);
        send_bytes("basic", 0, 1'b0);
        wait_drain("basic");
        check("basic_checksum", 32'(checksum), 32'(exp_sum(16'h401D)));

        // Zero-length load: done in the cycle following the start cycle, never ready.
        exp_q.push_back(mk(EV_DONE, 16'h0, 16'h0));
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 16'h0008;
        len_words = 16'd0;
        @(negedge clk);
        check("zero_in_ready_c0", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_done_pulse", 32'(done), 32'd1);
        check("zero_in_ready_c1", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("zero_done_cleared", 32'(done), 32'd0);
        check("zero_in_ready_c2", 32'(in_ready), 32'd0);
        wait_drain("zero");
        check("zero_checksum", 32'(checksum), 32'd0);

        // Overflow: second word would exceed the 32-byte memory.
        tx = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_q.push_back(mk(EV_WRITE, 16'h001E, 16'hBBAA));
        exp_q.push_back(mk(EV_ERROR, 16'h0, 16'h0));
        start_load(16'h001E, 16'd2);
        send_bytes("ovf", 0, 1'b0);
        wait_drain("ovf");
        check("ovf_checksum", 32'(checksum), 32'(exp_sum(16'hBBAA)));

        // Stalled stream with an ignored start while busy.
        tx = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back(mk(EV_WRITE, 16'h0004, 16'h2211));
        exp_q.push_back(mk(EV_WRITE, 16'h0006, 16'h4433));
        exp_q.push_back(mk(EV_DONE, 16'h0, 16'h0));
        start_load(16'h0004, 16'd2);
        send_bytes("stall", 1, 1'b1);
        wait_drain("stall");
        check("stall_checksum", 32'(checksum), 32'(exp_sum(16'h6644)));

        // Reset while waiting for the high byte.
        start_load(16'h0000, 16'd1);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'h34;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h12;
        @(negedge clk);
        check("mid_in_ready_get_hi", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst2_busy",     32'(busy), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd0);
        check("rst2_waddr",    32'(waddr), 32'd0);
        check("rst2_wdata",    32'(wdata), 32'd0);
        check("rst2_checksum", 32'(checksum), 32'd0);
        repeat (3) @(negedge clk);
        check("rst2_no_we", 32'(we), 32'd0);

        tx = '{8'h78, 8'h56};
        exp_q.push_back(mk(EV_WRITE, 16'h0000, 16'h5678));
        exp_q.push_back(mk(EV_DONE, 16'h0, 16'h0));
        start_load(16'h0000, 16'd1);
        send_bytes("post_rst", 0, 1'b0);
        wait_drain("post_rst");
        check("post_rst_checksum", 32'(checksum), 32'(exp_sum(16'h5678)));

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
